// File: rtl/cw_capture_ctrl_if.sv
// ChipWatcher capture-control bundle.
// Groups the capture-engine handshake and configuration/status signals so the
// JTAG control-register side and the capture engine share one port.
//   master : drives arm/abort, probe data and trigger configuration,
//            receives sample-RAM write strobes and capture status.
//   slave  : the capture engine (cw_capture_ctrl).
interface cw_capture_ctrl_if #(
  parameter int NUM_CH   = 3,
  parameter int CH_WIDTH = 16,
  parameter int ADDR_W   = 10
);
  localparam int DW = NUM_CH * CH_WIDTH;

  logic              arm;
  logic              abort;
  logic [DW-1:0]     bus_din;
  logic [DW-1:0]     trig_val;
  logic [DW-1:0]     trig_mask;
  logic [NUM_CH-1:0] trig_edge;
  logic [NUM_CH-1:0] ch_en;
  logic              trig_mode;
  logic [ADDR_W-1:0] pre_len;

  logic              wt_ce;
  logic              wt_en;
  logic [ADDR_W-1:0] wt_addr;
  logic [DW-1:0]     wt_data;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic              busy;
  logic              done;

  modport master (
    output arm, abort, bus_din, trig_val, trig_mask, trig_edge, ch_en,
           trig_mode, pre_len,
    input  wt_ce, wt_en, wt_addr, wt_data, trig_addr, start_addr, busy, done
  );

  modport slave (
    input  arm, abort, bus_din, trig_val, trig_mask, trig_edge, ch_en,
           trig_mode, pre_len,
    output wt_ce, wt_en, wt_addr, wt_data, trig_addr, start_addr, busy, done
  );
endinterface

// File: rtl/cw_capture_ctrl.sv
// ChipWatcher trigger/capture engine.
// Samples NUM_CH probe buses each trig_clk, evaluates per-channel value/mask
// (level or rising-edge) triggers combined by AND/OR, and writes a circular
// sample RAM holding pre_len samples before the trigger sample and
// DEPTH-1-pre_len samples after it.
// Ports:
//   trig_clk  : capture clock
//   trig_rstn : asynchronous active-low reset
//   cw        : cw_capture_ctrl_if.slave -- arm/abort, probe data, trigger
//               config in; sample-RAM write port and status out
module cw_capture_ctrl #(
  parameter int NUM_CH   = 3,
  parameter int CH_WIDTH = 16,
  parameter int ADDR_W   = 10
) (
  input  logic             trig_clk,
  input  logic             trig_rstn,
  cw_capture_ctrl_if.slave cw
);
  localparam int DW = NUM_CH * CH_WIDTH;

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DW-1:0]     s1_p0;
  logic [NUM_CH-1:0] m;
  logic [NUM_CH-1:0] m_d;
  logic [NUM_CH-1:0] hit;
  logic              trig_fire;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] pre_cnt_inc;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] post_init;
  logic              arm_go;
  logic              do_write;
  logic              load_trig;

  // Trigger evaluation on the registered sample
  always_comb begin
    logic and_t;
    logic or_t;
    m     = '0;
    hit   = '0;
    and_t = 1'b1;
    or_t  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m[i]   = &(~(s1_p0[i*CH_WIDTH +: CH_WIDTH] ^ cw.trig_val[i*CH_WIDTH +: CH_WIDTH])
                 | ~cw.trig_mask[i*CH_WIDTH +: CH_WIDTH]);
      hit[i] = cw.trig_edge[i] ? (m[i] & ~m_d[i]) : m[i];
      // Disabled channels are neutral for the selected combine mode.
      if (cw.ch_en[i]) begin
        and_t = and_t & hit[i];
        or_t  = or_t | hit[i];
      end
    end
    // With no channel enabled the AND reduction would be vacuously true.
    trig_fire = (|cw.ch_en) & (cw.trig_mode ? or_t : and_t);
  end

  assign pre_cnt_inc = pre_cnt + 1'b1;
  assign post_init   = {ADDR_W{1'b1}} - cw.pre_len;
  assign arm_go      = cw.arm & ~cw.abort & ((state == IDLE) | (state == DONE));

  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    load_trig = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (arm_go) state_nxt = (cw.pre_len == '0) ? ARMED : PRE;
      end
      PRE: begin
        do_write = 1'b1;
        if (pre_cnt_inc == cw.pre_len) state_nxt = ARMED;
      end
      ARMED: begin
        do_write = 1'b1;
        if (trig_fire) begin
          load_trig = 1'b1;
          state_nxt = (post_init == '0) ? DONE : POST;
        end
      end
      POST: begin
        do_write = 1'b1;
        if (post_cnt == ADDR_W'(1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (cw.abort) begin
      state_nxt = IDLE;
      do_write  = 1'b0;
      load_trig = 1'b0;
    end
  end

  always_ff @(posedge trig_clk or negedge trig_rstn) begin
    if (!trig_rstn) begin
      state         <= IDLE;
      s1_p0         <= '0;
      m_d           <= '0;
      wr_ptr        <= '0;
      pre_cnt       <= '0;
      post_cnt      <= '0;
      cw.wt_ce      <= 1'b0;
      cw.wt_en      <= 1'b0;
      cw.wt_addr    <= '0;
      cw.wt_data    <= '0;
      cw.trig_addr  <= '0;
      cw.start_addr <= '0;
      cw.busy       <= 1'b0;
      cw.done       <= 1'b0;
    end else begin
      // Stage p0: probe sample register
      s1_p0 <= cw.bus_din;
      m_d   <= arm_go ? '0 : m;

      state    <= state_nxt;
      cw.busy  <= (state_nxt == PRE) | (state_nxt == ARMED) | (state_nxt == POST);
      cw.done  <= (state_nxt == DONE);
      cw.wt_ce <= (state_nxt != IDLE);

      // Stage p1: sample-RAM write port
      cw.wt_en <= do_write;
      if (do_write) begin
        cw.wt_addr <= wr_ptr;
        cw.wt_data <= s1_p0;
        wr_ptr     <= wr_ptr + 1'b1;
      end

      if (arm_go) begin
        wr_ptr  <= '0;
        pre_cnt <= '0;
      end else if (state == PRE && do_write) begin
        pre_cnt <= pre_cnt_inc;
      end

      if (load_trig) begin
        cw.trig_addr  <= wr_ptr;
        cw.start_addr <= wr_ptr - cw.pre_len;
        post_cnt      <= post_init;
      end else if (state == POST && do_write) begin
        post_cnt <= post_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cw_capture_ctrl.sv
module tb_cw_capture_ctrl;
  logic trig_clk;
  logic trig_rstn;
  int   vectors;
  int   miscompares;

  logic [3:0]  wa[$];
  logic [15:0] wd[$];

  cw_capture_ctrl_if #(.NUM_CH(2), .CH_WIDTH(8), .ADDR_W(4)) cw ();

  cw_capture_ctrl #(.NUM_CH(2), .CH_WIDTH(8), .ADDR_W(4)) dut (
    .trig_clk (trig_clk),
    .trig_rstn(trig_rstn),
    .cw       (cw)
  );

  initial trig_clk = 1'b0;
  always #5 trig_clk = ~trig_clk;

  // Sample outputs at the falling edge (recording writes), then drive inputs.
  task automatic cyc(input logic [7:0] d0, input logic [7:0] d1,
                     input logic a, input logic ab);
    @(negedge trig_clk);
    if (cw.wt_en) begin
      wa.push_back(cw.wt_addr);
      wd.push_back(cw.wt_data);
    end
    cw.bus_din = {d1, d0};
    cw.arm     = a;
    cw.abort   = ab;
  endtask

  task automatic run_until_done(input logic [7:0] d0, input logic [7:0] d1,
                                input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc(d0, d1, 1'b0, 1'b0);
      if (cw.done) ok = 1'b1;
    end
  endtask

  task automatic cfg(input logic [7:0] v0, input logic [7:0] v1,
                     input logic [1:0] edg, input logic [1:0] en,
                     input logic mode, input logic [3:0] pl);
    cw.trig_val  = {v1, v0};
    cw.trig_mask = 16'hFFFF;
    cw.trig_edge = edg;
    cw.ch_en     = en;
    cw.trig_mode = mode;
    cw.pre_len   = pl;
  endtask

  task automatic test_reset();
    trig_rstn = 1'b0;
    repeat (2) @(negedge trig_clk);
    vectors++;
    if ({cw.busy, cw.done, cw.wt_ce, cw.wt_en} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 0000", {cw.busy, cw.done, cw.wt_ce, cw.wt_en});
    end
    vectors++;
    if ({cw.wt_addr, cw.wt_data, cw.trig_addr, cw.start_addr} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 0",
               {cw.wt_addr, cw.wt_data, cw.trig_addr, cw.start_addr});
    end
    trig_rstn = 1'b1;
  endtask

  task automatic test_basic();
    logic ok;
    int   bad;
    cfg(8'h5A, 8'h00, 2'b00, 2'b01, 1'b0, 4'd4);
    wa.delete(); wd.delete();
    cyc(8'h50, 8'h00, 1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 1; i < 60 && !ok; i++) begin
      cyc(8'h50 + 8'(i), 8'h00, 1'b0, 1'b0);
      if (cw.done) ok = 1'b1;
    end
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_done: got %b expected 1", ok);
    end
    vectors++;
    if (wa.size() !== 22) begin
      miscompares++;
      $display("FAIL basic_write_count: got %0d expected 22", wa.size());
    end
    bad = 0;
    for (int k = 0; k < 22 && k < wa.size(); k++)
      if (wa[k] !== 4'(k) || wd[k] !== 16'h0050 + 16'(k)) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL basic_stream: got %0d bad writes expected 0", bad);
    end
    vectors++;
    if (cw.trig_addr !== 4'd10 || cw.start_addr !== 4'd6) begin
      miscompares++;
      $display("FAIL basic_addrs: got trig %0d start %0d expected 10 6", cw.trig_addr, cw.start_addr);
    end
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    vectors++;
    if ({cw.wt_en, cw.wt_ce, cw.busy, cw.done} !== 4'b0101 || wa.size() !== 22) begin
      miscompares++;
      $display("FAIL basic_done_hold: got en/ce/busy/done %b writes %0d expected 0101 22",
               {cw.wt_en, cw.wt_ce, cw.busy, cw.done}, wa.size());
    end
  endtask

  task automatic test_pre_only();
    logic ok;
    cfg(8'h5A, 8'h00, 2'b00, 2'b01, 1'b0, 4'd4);
    cyc(8'h5A, 8'h00, 1'b1, 1'b0);
    repeat (3) cyc(8'h5A, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    repeat (3) cyc(8'h00, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (cw.busy !== 1'b1 || cw.done !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_only_no_trig: got busy %b done %b expected 1 0", cw.busy, cw.done);
    end
    cyc(8'h5A, 8'h00, 1'b0, 1'b0);
    run_until_done(8'h00, 8'h00, 40, ok);
    vectors++;
    if (ok !== 1'b1 || cw.trig_addr !== 4'd9 || cw.start_addr !== 4'd5) begin
      miscompares++;
      $display("FAIL pre_only_retrig: got done %b trig %0d start %0d expected 1 9 5",
               ok, cw.trig_addr, cw.start_addr);
    end
  endtask

  task automatic test_edge();
    logic ok;
    logic saw_done;
    cfg(8'h5A, 8'h00, 2'b01, 2'b01, 1'b0, 4'd2);
    cyc(8'h5A, 8'h00, 1'b1, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(8'h5A, 8'h00, 1'b0, 1'b0);
      if (cw.done) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0 || cw.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL edge_held_no_trig: got done %b busy %b expected 0 1", saw_done, cw.busy);
    end
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h5A, 8'h00, 1'b0, 1'b0);
    run_until_done(8'h5A, 8'h00, 40, ok);
    vectors++;
    if (ok !== 1'b1 || cw.trig_addr !== 4'd3 || cw.start_addr !== 4'd1) begin
      miscompares++;
      $display("FAIL edge_rise: got done %b trig %0d start %0d expected 1 3 1",
               ok, cw.trig_addr, cw.start_addr);
    end
  endtask

  task automatic test_or_mode();
    logic ok;
    logic saw_done;
    cfg(8'h11, 8'h22, 2'b00, 2'b11, 1'b1, 4'd1);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h22, 1'b0, 1'b0);
    run_until_done(8'h00, 8'h00, 40, ok);
    vectors++;
    if (ok !== 1'b1 || cw.trig_addr !== 4'd2 || cw.start_addr !== 4'd1) begin
      miscompares++;
      $display("FAIL or_ch1: got done %b trig %0d start %0d expected 1 2 1",
               ok, cw.trig_addr, cw.start_addr);
    end
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h11, 8'h00, 1'b0, 1'b0);
    run_until_done(8'h00, 8'h00, 40, ok);
    vectors++;
    if (ok !== 1'b1 || cw.trig_addr !== 4'd3 || cw.start_addr !== 4'd2) begin
      miscompares++;
      $display("FAIL or_ch0: got done %b trig %0d start %0d expected 1 3 2",
               ok, cw.trig_addr, cw.start_addr);
    end
    cfg(8'h11, 8'h22, 2'b00, 2'b00, 1'b0, 4'd1);
    cyc(8'h11, 8'h22, 1'b1, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(8'h11, 8'h22, 1'b0, 1'b0);
      if (cw.done) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0 || cw.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL no_channels: got done %b busy %b expected 0 1", saw_done, cw.busy);
    end
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    cfg(8'h5A, 8'h00, 2'b00, 2'b01, 1'b0, 4'd15);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    repeat (14) cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h5A, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (cw.busy !== 1'b1 || cw.wt_addr !== 4'd14) begin
      miscompares++;
      $display("FAIL wrap_pre_end: got busy %b addr %0d expected 1 14", cw.busy, cw.wt_addr);
    end
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (cw.done !== 1'b1 || cw.wt_en !== 1'b1 || cw.wt_addr !== 4'd15 ||
        cw.wt_data !== 16'h005A) begin
      miscompares++;
      $display("FAIL wrap_trig_write: got done %b en %b addr %0d data %h expected 1 1 15 005a",
               cw.done, cw.wt_en, cw.wt_addr, cw.wt_data);
    end
    vectors++;
    if (cw.trig_addr !== 4'd15 || cw.start_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap_addrs: got trig %0d start %0d expected 15 0", cw.trig_addr, cw.start_addr);
    end
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (cw.wt_en !== 1'b0 || cw.done !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_after: got en %b done %b expected 0 1", cw.wt_en, cw.done);
    end
  endtask

  task automatic test_abort();
    cfg(8'h5A, 8'h00, 2'b00, 2'b01, 1'b0, 4'd4);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    repeat (3) cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h5A, 8'h00, 1'b0, 1'b0);
    repeat (4) cyc(8'h00, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (cw.busy !== 1'b1 || cw.wt_en !== 1'b1 || cw.trig_addr !== 4'd4) begin
      miscompares++;
      $display("FAIL abort_in_post: got busy %b en %b trig %0d expected 1 1 4",
               cw.busy, cw.wt_en, cw.trig_addr);
    end
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    vectors++;
    if ({cw.wt_en, cw.busy, cw.done, cw.wt_ce} !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort_idle: got en/busy/done/ce %b expected 0000",
               {cw.wt_en, cw.busy, cw.done, cw.wt_ce});
    end
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (cw.busy !== 1'b0 || cw.wt_ce !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_beats_arm: got busy %b ce %b expected 0 0", cw.busy, cw.wt_ce);
    end
  endtask

  task automatic test_reset_mid();
    cfg(8'h5A, 8'h00, 2'b00, 2'b01, 1'b0, 4'd4);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    repeat (6) cyc(8'h00, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (cw.busy !== 1'b1 || cw.wt_ce !== 1'b1 || cw.wt_en !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got busy %b ce %b en %b expected 1 1 1",
               cw.busy, cw.wt_ce, cw.wt_en);
    end
    @(negedge trig_clk);
    #1 trig_rstn = 1'b0;
    #1;
    vectors++;
    if ({cw.busy, cw.done, cw.wt_ce, cw.wt_en, cw.wt_addr, cw.wt_data,
         cw.trig_addr, cw.start_addr} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %h expected 0",
               {cw.busy, cw.done, cw.wt_ce, cw.wt_en, cw.wt_addr, cw.wt_data,
                cw.trig_addr, cw.start_addr});
    end
    @(negedge trig_clk);
    trig_rstn = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    trig_rstn   = 1'b0;
    cw.arm      = 1'b0;
    cw.abort    = 1'b0;
    cw.bus_din  = '0;
    cfg(8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 4'd0);
    test_reset();
    test_basic();
    test_pre_only();
    test_edge();
    test_or_mode();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
